// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: read pointer, empty,
// almost-empty, fill level and underflow reporting in the rclk domain.
//
// Ports:
//   rclk           read-domain clock
//   rrst_n         synchronous active-low reset
//   rinc           read request from the consumer
//   rq2_wptr       Gray write pointer, already synchronized into rclk
//   rptr           registered Gray read pointer for the write domain
//   raddr          binary read address into the shared memory
//   rempty         registered empty flag
//   ralmost_empty  registered flag, fill level <= P_AE_THRESH
//   rlevel         registered fill-level estimate
//   rerr_underflow one-cycle pulse on a read rejected while empty
module fifo_rd_ctrl #(
    parameter int P_WIDTH     = 4,
    parameter int P_AE_THRESH = 2
) (
    input  logic               rclk,
    input  logic               rrst_n,
    input  logic               rinc,
    input  logic [P_WIDTH-1:0] rq2_wptr,
    output logic [P_WIDTH-1:0] rptr,
    output logic [P_WIDTH-2:0] raddr,
    output logic               rempty,
    output logic               ralmost_empty,
    output logic [P_WIDTH-1:0] rlevel,
    output logic               rerr_underflow
);

    localparam logic [P_WIDTH-1:0] LP_AE = P_WIDTH'(P_AE_THRESH);

    logic [P_WIDTH-1:0] r_bin;
    logic [P_WIDTH-1:0] r_ptr;
    logic [P_WIDTH-1:0] r_level;
    logic               r_empty;
    logic               r_aempty;
    logic               r_uflow;

    logic               w_accept;
    logic [P_WIDTH-1:0] w_bin_next;
    logic [P_WIDTH-1:0] w_gray_next;
    logic [P_WIDTH-1:0] w_wbin;
    logic [P_WIDTH-1:0] w_level_next;

    // Gating uses the registered empty flag only, so rinc never reaches
    // an output combinationally.
    assign w_accept    = rinc & ~r_empty;
    assign w_bin_next  = r_bin + {{(P_WIDTH-1){1'b0}}, w_accept};
    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

    // Gray to binary: bit i is the XOR of all Gray bits from MSB down to i.
    always_comb begin
        w_wbin = '0;
        for (int i = 0; i < P_WIDTH; i++) begin
            w_wbin[i] = ^(rq2_wptr >> i);
        end
    end

    // Modulo difference; the wrap bit lets a full FIFO read as 2^(W-1).
    assign w_level_next = w_wbin - w_bin_next;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_bin    <= '0;
            r_ptr    <= '0;
            r_level  <= '0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
            r_uflow  <= 1'b0;
        end else begin
            r_bin    <= w_bin_next;
            r_ptr    <= w_gray_next;
            r_level  <= w_level_next;
            r_empty  <= (w_gray_next == rq2_wptr);
            r_aempty <= (w_level_next <= LP_AE);
            r_uflow  <= rinc & r_empty;
        end
    end

    assign rptr           = r_ptr;
    assign raddr          = r_bin[P_WIDTH-2:0];
    assign rempty         = r_empty;
    assign ralmost_empty  = r_aempty;
    assign rlevel         = r_level;
    assign rerr_underflow = r_uflow;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed testbench for fifo_rd_ctrl (P_WIDTH=4, P_AE_THRESH=2).
// Each scenario task drives stimulus and checks outputs after the edge.
module tb_fifo_rd_ctrl;

    logic       rclk;
    logic       rrst_n;
    logic       rinc;
    logic [3:0] rq2_wptr;
    logic [3:0] rptr;
    logic [2:0] raddr;
    logic       rempty;
    logic       ralmost_empty;
    logic [3:0] rlevel;
    logic       rerr_underflow;

    int checks = 0;
    int errors = 0;

    // Gray code of 0..15
    logic [3:0] g [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                           4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    fifo_rd_ctrl #(.P_WIDTH(4), .P_AE_THRESH(2)) dut (
        .rclk           (rclk),
        .rrst_n         (rrst_n),
        .rinc           (rinc),
        .rq2_wptr       (rq2_wptr),
        .rptr           (rptr),
        .raddr          (raddr),
        .rempty         (rempty),
        .ralmost_empty  (ralmost_empty),
        .rlevel         (rlevel),
        .rerr_underflow (rerr_underflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic test_reset();
        rrst_n   = 1'b0;
        rinc     = 1'b1;
        rq2_wptr = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            // short high glitch on rrst_n between edges
            rrst_n = 1'b1;
            #2;
            rrst_n = 1'b0;
            checks++;
            if ({rptr, raddr, rempty, ralmost_empty, rlevel, rerr_underflow}
                !== {4'h0, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0}) begin
                errors++;
                $display("FAIL reset[%0d]: got ptr=%b addr=%0d e=%b ae=%b lvl=%0d uf=%b want 0000/0/1/1/0/0",
                         i, rptr, raddr, rempty, ralmost_empty, rlevel, rerr_underflow);
            end
        end
    endtask

    task automatic test_fill();
        rrst_n   = 1'b1;
        rinc     = 1'b0;
        rq2_wptr = 4'b0010;
        tick();
        checks++;
        if ({rptr, raddr, rempty, ralmost_empty, rlevel, rerr_underflow}
            !== {4'h0, 3'd0, 1'b0, 1'b0, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL fill: got ptr=%b addr=%0d e=%b ae=%b lvl=%0d uf=%b want 0000/0/0/0/3/0",
                     rptr, raddr, rempty, ralmost_empty, rlevel, rerr_underflow);
        end
    endtask

    task automatic test_drain();
        logic [3:0] e_ptr [3] = '{4'b0001, 4'b0011, 4'b0010};
        logic [2:0] e_addr [3] = '{3'd1, 3'd2, 3'd3};
        logic [3:0] e_lvl [3] = '{4'd2, 4'd1, 4'd0};
        logic       e_emp [3] = '{1'b0, 1'b0, 1'b1};
        rinc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({rptr, raddr, rempty, ralmost_empty, rlevel, rerr_underflow}
                !== {e_ptr[i], e_addr[i], e_emp[i], 1'b1, e_lvl[i], 1'b0}) begin
                errors++;
                $display("FAIL drain[%0d]: got ptr=%b addr=%0d e=%b ae=%b lvl=%0d uf=%b want %b/%0d/%b/1/%0d/0",
                         i, rptr, raddr, rempty, ralmost_empty, rlevel, rerr_underflow,
                         e_ptr[i], e_addr[i], e_emp[i], e_lvl[i]);
            end
        end
    endtask

    task automatic test_underflow();
        rinc = 1'b1;
        tick();
        checks++;
        if ({rptr, raddr, rempty, rlevel, rerr_underflow}
            !== {4'b0010, 3'd3, 1'b1, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL underflow: got ptr=%b addr=%0d e=%b lvl=%0d uf=%b want 0010/3/1/0/1",
                     rptr, raddr, rempty, rlevel, rerr_underflow);
        end
        rinc = 1'b0;
        tick();
        checks++;
        if ({rptr, raddr, rempty, rlevel, rerr_underflow}
            !== {4'b0010, 3'd3, 1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL underflow_clear: got ptr=%b addr=%0d e=%b lvl=%0d uf=%b want 0010/3/1/0/0",
                     rptr, raddr, rempty, rlevel, rerr_underflow);
        end
    endtask

    // Accepted read with the write pointer kept 8 entries ahead of rbin=b.
    task automatic read_ahead(input int b, input string tag);
        rq2_wptr = g[(b + 8) % 16];
        rinc     = 1'b1;
        tick();
        checks++;
        if ({rptr, raddr, rempty, ralmost_empty, rlevel, rerr_underflow}
            !== {g[(b + 1) % 16], 3'((b + 1) % 8), 1'b0, 1'b0, 4'd7, 1'b0}) begin
            errors++;
            $display("FAIL %s[%0d]: got ptr=%b addr=%0d e=%b ae=%b lvl=%0d uf=%b want %b/%0d/0/0/7/0",
                     tag, b, rptr, raddr, rempty, ralmost_empty, rlevel, rerr_underflow,
                     g[(b + 1) % 16], (b + 1) % 8);
        end
    endtask

    task automatic test_full_wrap();
        rrst_n   = 1'b0;
        rinc     = 1'b0;
        rq2_wptr = 4'b1100;
        tick();
        rrst_n = 1'b1;
        tick();
        checks++;
        if ({rptr, raddr, rempty, ralmost_empty, rlevel}
            !== {4'h0, 3'd0, 1'b0, 1'b0, 4'd8}) begin
            errors++;
            $display("FAIL full: got ptr=%b addr=%0d e=%b ae=%b lvl=%0d want 0000/0/0/0/8",
                     rptr, raddr, rempty, ralmost_empty, rlevel);
        end
        for (int b = 0; b < 16; b++) read_ahead(b, "wrap");
        checks++;
        if ({rptr, raddr} !== {4'h0, 3'd0}) begin
            errors++;
            $display("FAIL wrap_end: got ptr=%b addr=%0d want 0000/0", rptr, raddr);
        end
    endtask

    task automatic test_mid_reset();
        for (int b = 0; b < 5; b++) read_ahead(b, "pre_rst");
        rrst_n   = 1'b0;
        rinc     = 1'b1;
        rq2_wptr = 4'b0010;
        tick();
        checks++;
        if ({rptr, raddr, rempty, ralmost_empty, rlevel, rerr_underflow}
            !== {4'h0, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got ptr=%b addr=%0d e=%b ae=%b lvl=%0d uf=%b want 0000/0/1/1/0/0",
                     rptr, raddr, rempty, ralmost_empty, rlevel, rerr_underflow);
        end
        rrst_n = 1'b1;
        rinc   = 1'b0;
        tick();
        checks++;
        if ({rptr, raddr, rempty, ralmost_empty, rlevel, rerr_underflow}
            !== {4'h0, 3'd0, 1'b0, 1'b0, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL post_reset: got ptr=%b addr=%0d e=%b ae=%b lvl=%0d uf=%b want 0000/0/0/0/3/0",
                     rptr, raddr, rempty, ralmost_empty, rlevel, rerr_underflow);
        end
        rinc = 1'b1;
        tick();
        checks++;
        if ({rptr, raddr, rempty, ralmost_empty, rlevel, rerr_underflow}
            !== {4'b0001, 3'd1, 1'b0, 1'b1, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL resume: got ptr=%b addr=%0d e=%b ae=%b lvl=%0d uf=%b want 0001/1/0/1/2/0",
                     rptr, raddr, rempty, ralmost_empty, rlevel, rerr_underflow);
        end
        rinc = 1'b0;
    endtask

    initial begin
        rrst_n   = 1'b0;
        rinc     = 1'b0;
        rq2_wptr = 4'b0000;
        test_reset();
        test_fill();
        test_drain();
        test_underflow();
        test_full_wrap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter P_WIDTH, default 4: pointer width including wrap bit; FIFO depth = 2^(P_WIDTH-1); legal range >= 3.
REQ-002 Parameter P_AE_THRESH, default 2: almost-empty threshold in entries; legal range 0 to 2^(P_WIDTH-1).
REQ-003 rclk  input  1  read-domain clock; all state updates on the rising edge.
REQ-004 rrst_n  input  1  reset, synchronous, active-low; sampled only on the rclk rising edge.
REQ-005 rinc  input  1  read request from the consumer.
REQ-006 rq2_wptr  input  P_WIDTH  Gray-coded write pointer, already two-flop synchronized into rclk.
REQ-007 rptr  output  P_WIDTH  registered Gray-coded read pointer, sent to the write domain.
REQ-008 raddr  output  P_WIDTH-1  binary read address into the shared memory.
REQ-009 rempty  output  1  registered empty flag.
REQ-010 ralmost_empty  output  1  registered flag; set when fill level <= P_AE_THRESH.
REQ-011 rlevel  output  P_WIDTH  registered fill-level estimate, 0 to 2^(P_WIDTH-1).
REQ-012 rerr_underflow  output  1  one-cycle pulse on a rejected read.

Function
REQ-013 Internal binary read counter rbin, P_WIDTH bits, wraps modulo 2^P_WIDTH.
REQ-014 Read accepted = rinc AND NOT rempty, using the registered rempty; rbin_next = rbin + accepted.
REQ-015 raddr = rbin[P_WIDTH-2:0] (current, not next), driven directly from the register with no added latency.
REQ-016 Each edge: rptr <= gray(rbin_next), where gray(x) = x XOR (x >> 1).
REQ-017 Each edge: rempty <= (gray(rbin_next) == rq2_wptr); all P_WIDTH bits compared.
REQ-018 wbin = Gray-to-binary of rq2_wptr (MSB passes through; bit i = XOR of bits P_WIDTH-1 down to i), combinational.
REQ-019 Each edge: rlevel <= (wbin - rbin_next) modulo 2^P_WIDTH; a value of 2^(P_WIDTH-1) means full.
REQ-020 Each edge: ralmost_empty <= (level_next <= P_AE_THRESH), where level_next is the value loaded into rlevel.
REQ-021 Each edge: rerr_underflow <= rinc AND rempty; rbin, rptr and raddr do not change on a rejected read.
REQ-022 Latency: an accepted read on edge N updates raddr, rptr, rempty, rlevel and ralmost_empty after edge N; no combinational path from rinc to any output.
REQ-023 Wrap: rbin 2^P_WIDTH-1 -> 0 is seamless; the raddr MSB-less index wraps every 2^(P_WIDTH-1) reads.
REQ-024 Simultaneous write-pointer advance and read: the flags reflect the rq2_wptr sampled on the same edge as rbin_next; a stale rq2_wptr only makes the flags pessimistic (never a false non-empty).
REQ-025 rlevel is advisory; rempty alone gates reads.

Reset
REQ-026 When rrst_n = 0 at an rclk edge: rbin = 0, rptr = 0, raddr = 0, rempty = 1, ralmost_empty = 1, rlevel = 0, rerr_underflow = 0; rinc is ignored.
REQ-027 Reset has priority over every other update, including mid-operation; there is no asynchronous reset path.
REQ-028 After rrst_n returns to 1, the flags re-evaluate against rq2_wptr on the first edge.

Verification (P_WIDTH=4, P_AE_THRESH=2)
REQ-029 Reset: rrst_n=0, rinc=1, rq2_wptr=0010 for 3 edges -> all outputs hold their reset values; a glitch on rrst_n between edges has no effect.
REQ-030 Fill: rq2_wptr=0010 (binary 3), rinc=0, one edge -> rempty=0, rlevel=3, ralmost_empty=0, raddr=0.
REQ-031 Drain: continue from REQ-030 with rinc=1 for 3 edges.
  - raddr steps 1, 2, 3.
  - rptr steps 0001, 0011, 0010.
  - rlevel steps 2, 1, 0.
  - ralmost_empty=1 from the first edge.
  - rempty=1 after the third edge.
REQ-032 Underflow: with rempty=1, rinc=1 for one edge -> rerr_underflow=1 for exactly one cycle; rptr, raddr and rlevel are unchanged.
REQ-033 Full/wrap:
  - rbin=0 with rq2_wptr=1100 (binary 8) -> rlevel=8, rempty=0.
  - 16 accepted reads with rq2_wptr advanced ahead -> raddr wraps 7->0 and rptr goes 1000->0000 at rbin 15->0.
REQ-034 Mid-operation reset: with rbin=5 and rempty=0, rrst_n=0 for one edge -> the REQ-026 values on the next cycle; reads resume from raddr 0.
